// File: rtl/inject_run_ctrl.sv
// rtl/inject_run_ctrl.sv - fault-injection run controller: N runs of offset-wait then inject window.
// Optional ignored-start counter on overrun_cnt when FAULTIFY_INJ_OVERRUN_CNT_EN is defined.
module inject_run_ctrl #(
  parameter int CNT_W = 32,
  parameter int RUN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_pulse,
  input  logic             abort_pulse,
  input  logic [CNT_W-1:0] cfg_offset,
  input  logic [CNT_W-1:0] cfg_length,
  input  logic [RUN_W-1:0] cfg_runs,
  input  logic             clr_overrun,
  output logic             inject_en,
  output logic             busy,
  output logic             done_pulse,
  output logic             aborted,
  output logic [RUN_W-1:0] run_idx,
  output logic             overrun,
  output logic [7:0]       overrun_cnt
);

  typedef enum logic [1:0] {IDLE, OFFSET, INJECT, DONE} state_t;

  state_t           state, stateNext, eorState;
  logic [CNT_W-1:0] cnt, cntNext, eorCnt;
  logic [CNT_W-1:0] offsetR, lengthR;
  logic [RUN_W-1:0] runsR, runsIn, runIdxNext, eorIdx;
  logic             abortedNext;
  logic             startAcc, startIgn, lastRun;

  assign startAcc = start_pulse && !abort_pulse && (state == IDLE);
  assign startIgn = start_pulse && (state != IDLE);
  assign runsIn   = (cfg_runs == '0) ? RUN_W'(1) : cfg_runs;
  assign lastRun  = ({1'b0, run_idx} + (RUN_W+1)'(1)) >= {1'b0, runsR};

  // End-of-run target; a non-empty first run guarantees every follow-on run is non-empty too.
  always_comb begin
    eorState = DONE;
    eorCnt   = cnt;
    eorIdx   = run_idx;
    if (!lastRun) begin
      eorIdx = run_idx + RUN_W'(1);
      if (offsetR != '0) begin
        eorState = OFFSET;
        eorCnt   = offsetR;
      end else begin
        eorState = INJECT;
        eorCnt   = lengthR;
      end
    end
  end

  always_comb begin
    stateNext   = state;
    cntNext     = cnt;
    runIdxNext  = run_idx;
    abortedNext = aborted;
    case (state)
      IDLE: begin
        if (startAcc) begin
          runIdxNext  = '0;
          abortedNext = 1'b0;
          if (cfg_offset != '0) begin
            stateNext = OFFSET;
            cntNext   = cfg_offset;
          end else if (cfg_length != '0) begin
            stateNext = INJECT;
            cntNext   = cfg_length;
          end else begin
            // every run is empty: collapse the whole sequence into DONE
            stateNext  = DONE;
            runIdxNext = runsIn - RUN_W'(1);
          end
        end
      end
      OFFSET: begin
        if (abort_pulse) begin
          stateNext   = DONE;
          abortedNext = 1'b1;
        end else if (cnt <= CNT_W'(1)) begin
          if (lengthR != '0) begin
            stateNext = INJECT;
            cntNext   = lengthR;
          end else begin
            stateNext  = eorState;
            cntNext    = eorCnt;
            runIdxNext = eorIdx;
          end
        end else begin
          cntNext = cnt - CNT_W'(1);
        end
      end
      INJECT: begin
        if (abort_pulse) begin
          stateNext   = DONE;
          abortedNext = 1'b1;
        end else if (cnt <= CNT_W'(1)) begin
          stateNext  = eorState;
          cntNext    = eorCnt;
          runIdxNext = eorIdx;
        end else begin
          cntNext = cnt - CNT_W'(1);
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      offsetR    <= '0;
      lengthR    <= '0;
      runsR      <= '0;
      run_idx    <= '0;
      aborted    <= 1'b0;
      inject_en  <= 1'b0;
      busy       <= 1'b0;
      done_pulse <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      cnt        <= cntNext;
      run_idx    <= runIdxNext;
      aborted    <= abortedNext;
      inject_en  <= (stateNext == INJECT);
      busy       <= (stateNext != IDLE);
      done_pulse <= (stateNext == DONE);
      if (startAcc) begin
        offsetR <= cfg_offset;
        lengthR <= cfg_length;
        runsR   <= runsIn;
      end
      if (startIgn)         overrun <= 1'b1;
      else if (clr_overrun) overrun <= 1'b0;
    end
  end

`ifdef FAULTIFY_INJ_OVERRUN_CNT_EN
  logic [7:0] ovCnt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovCnt <= '0;
    end else if (startIgn) begin
      if (clr_overrun)        ovCnt <= 8'd1;
      else if (ovCnt != 8'hFF) ovCnt <= ovCnt + 8'd1;
    end else if (clr_overrun) begin
      ovCnt <= '0;
    end
  end
  assign overrun_cnt = ovCnt;
`else
  assign overrun_cnt = '0;
`endif

endmodule

// File: tb/tb_inject_run_ctrl.sv
// tb/tb_inject_run_ctrl.sv - randomized self-checking bench for inject_run_ctrl against a trace model.
module tb_inject_run_ctrl;
  localparam int CNT_W = 32;
  localparam int RUN_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             start_pulse, abort_pulse, clr_overrun;
  logic [CNT_W-1:0] cfg_offset, cfg_length;
  logic [RUN_W-1:0] cfg_runs;
  logic             inject_en, busy, done_pulse, aborted, overrun;
  logic [RUN_W-1:0] run_idx;
  logic [7:0]       overrun_cnt;

  inject_run_ctrl #(.CNT_W(CNT_W), .RUN_W(RUN_W)) dut (
    .clk(clk), .rst(rst), .start_pulse(start_pulse), .abort_pulse(abort_pulse),
    .cfg_offset(cfg_offset), .cfg_length(cfg_length), .cfg_runs(cfg_runs),
    .clr_overrun(clr_overrun), .inject_en(inject_en), .busy(busy),
    .done_pulse(done_pulse), .aborted(aborted), .run_idx(run_idx),
    .overrun(overrun), .overrun_cnt(overrun_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {bit inj; bit bsy; bit dn; int idx;} ent_t;

  ent_t expQ[$];
  int   vecCnt = 0;
  int   errCnt = 0;
  bit   expAborted = 0;
  bit   expOverrun = 0;
  int   expOvCnt = 0;

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] want);
    vecCnt++;
    if (got !== want) begin
      errCnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic logic [7:0] ovExp();
`ifdef FAULTIFY_INJ_OVERRUN_CNT_EN
    return 8'(expOvCnt);
`else
    return 8'd0;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkState(input string tag, input ent_t e);
    checkVal(tag, {inject_en, busy, done_pulse, aborted, overrun, run_idx},
             {e.inj, e.bsy, e.dn, expAborted, expOverrun, 16'(e.idx)});
    checkVal({tag, "_ovcnt"}, overrun_cnt, ovExp());
  endtask

  // Cycle-by-cycle trace after the start edge: offset/inject slots per run, one DONE, then idle.
  task automatic buildExp(input int off, input int len, input int runs, input int abortAt);
    int re;
    ent_t e;
    int keepIdx;
    re = (runs == 0) ? 1 : runs;
    expQ.delete();
    if (off == 0 && len == 0) begin
      e = '{0, 1, 1, re - 1}; expQ.push_back(e);
    end else begin
      for (int r = 0; r < re; r++) begin
        for (int k = 0; k < off; k++) begin e = '{0, 1, 0, r}; expQ.push_back(e); end
        for (int k = 0; k < len; k++) begin e = '{1, 1, 0, r}; expQ.push_back(e); end
      end
      e = '{0, 1, 1, re - 1}; expQ.push_back(e);
    end
    e = '{0, 0, 0, re - 1}; expQ.push_back(e);
    if (abortAt >= 0) begin
      keepIdx = expQ[abortAt].idx;
      while (expQ.size() > abortAt + 1) void'(expQ.pop_back());
      e = '{0, 1, 1, keepIdx}; expQ.push_back(e);
      e = '{0, 0, 0, keepIdx}; expQ.push_back(e);
    end
  endtask

  task automatic runSeq(input int off, input int len, input int runs, input int abortAt, input int spurAt);
    buildExp(off, len, runs, abortAt);
    cfg_offset  = CNT_W'(off);
    cfg_length  = CNT_W'(len);
    cfg_runs    = RUN_W'(runs);
    start_pulse = 1'b1;
    tick();
    start_pulse = 1'b0;
    expAborted  = 0;
    checkState("seq_start", expQ[0]);
    for (int i = 0; i < expQ.size() - 1; i++) begin
      abort_pulse = (i == abortAt);
      start_pulse = (i == spurAt);
      cfg_offset  = $urandom;
      cfg_length  = $urandom;
      cfg_runs    = RUN_W'($urandom);
      tick();
      abort_pulse = 1'b0;
      start_pulse = 1'b0;
      if (i == abortAt) expAborted = 1;
      if (i == spurAt && expQ[i].bsy) begin
        expOverrun = 1;
        if (expOvCnt < 255) expOvCnt++;
      end
      checkState("seq_step", expQ[i + 1]);
    end
  endtask

  task automatic clearOverrun();
    clr_overrun = 1'b1;
    tick();
    clr_overrun = 1'b0;
    expOverrun  = 0;
    expOvCnt    = 0;
    checkVal("clr_overrun", {overrun, overrun_cnt}, {1'b0, 8'd0});
  endtask

  initial begin
    int off, len, runs, abortAt, spurAt, qsz;
    rst = 1'b1;
    start_pulse = 1'b0; abort_pulse = 1'b0; clr_overrun = 1'b0;
    cfg_offset = '0; cfg_length = '0; cfg_runs = '0;
    repeat (3) tick();
    checkVal("reset_state", {inject_en, busy, done_pulse, aborted, overrun, run_idx, overrun_cnt}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    checkVal("post_reset_idle", {busy, run_idx}, 64'd0);

    // directed scenarios from the expected-behaviour list
    runSeq(3, 2, 1, -1, -1);
    runSeq(0, 1, 3, -1, -1);
    runSeq(2, 0, 0, -1, -1);
    runSeq(1, 10, 1, 3, -1);
    runSeq(0, 0, 4, -1, -1);
    checkVal("aborted_cleared", aborted, 1'b0);

    // randomized sequences
    for (int s = 0; s < 40; s++) begin
      clearOverrun();
      off  = $urandom_range(0, 4);
      len  = $urandom_range(0, 4);
      runs = $urandom_range(0, 3);
      buildExp(off, len, runs, -1);
      qsz = expQ.size();
      abortAt = -1;
      spurAt  = -1;
      if (qsz > 2 && $urandom_range(0, 9) < 3) abortAt = $urandom_range(0, qsz - 3);
      if ($urandom_range(0, 9) < 3) begin
        if (abortAt >= 0) spurAt = $urandom_range(0, abortAt + 1);
        else              spurAt = $urandom_range(0, qsz - 2);
      end
      runSeq(off, len, runs, abortAt, spurAt);
    end

    // overrun: start+clr while busy, start in INJECT, start in DONE
    clearOverrun();
    cfg_offset = 0; cfg_length = 3; cfg_runs = 1;
    start_pulse = 1'b1; tick();
    clr_overrun = 1'b1; tick(); clr_overrun = 1'b0;
    tick();
    start_pulse = 1'b0; tick();
    checkVal("ovr_in_done", done_pulse, 1'b1);
    start_pulse = 1'b1; tick(); start_pulse = 1'b0;
    expOverrun = 1; expOvCnt = 3;
    checkVal("ovr_three", {busy, overrun, overrun_cnt}, {1'b0, 1'b1, ovExp()});

    // saturation of the ignored-start counter
    clearOverrun();
    cfg_offset = 0; cfg_length = 400; cfg_runs = 1;
    start_pulse = 1'b1; tick();
    repeat (300) tick();
    start_pulse = 1'b0;
    expOvCnt = 255;
    checkVal("ovr_saturate", {inject_en, overrun, overrun_cnt}, {1'b1, 1'b1, ovExp()});
    abort_pulse = 1'b1; tick(); abort_pulse = 1'b0;
    checkVal("abort_done", {inject_en, done_pulse, aborted}, {1'b0, 1'b1, 1'b1});
    abort_pulse = 1'b1; tick(); abort_pulse = 1'b0;
    checkVal("abort_in_done_ignored", {busy, done_pulse, aborted}, {1'b0, 1'b0, 1'b1});
    clearOverrun();

    // full-scale offset must count down, not wrap
    cfg_offset = '1; cfg_length = 2; cfg_runs = 1;
    start_pulse = 1'b1; tick(); start_pulse = 1'b0;
    repeat (5) tick();
    checkVal("fullscale_offset", {busy, inject_en, done_pulse}, {1'b1, 1'b0, 1'b0});
    abort_pulse = 1'b1; tick(); abort_pulse = 1'b0;
    checkVal("fullscale_abort", {busy, done_pulse}, {1'b1, 1'b1});
    tick();

    // asynchronous reset mid-INJECT
    cfg_offset = 0; cfg_length = 10; cfg_runs = 1;
    start_pulse = 1'b1; tick(); start_pulse = 1'b0;
    tick(); tick();
    checkVal("pre_reset_inject", inject_en, 1'b1);
    rst = 1'b1;
    #1;
    checkVal("async_reset", {inject_en, busy, done_pulse, aborted}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) tick();
    checkVal("idle_after_reset", {inject_en, busy, done_pulse, run_idx}, 64'd0);

    // start and abort together in IDLE
    cfg_offset = 1; cfg_length = 1; cfg_runs = 1;
    start_pulse = 1'b1; abort_pulse = 1'b1; tick();
    start_pulse = 1'b0; abort_pulse = 1'b0;
    checkVal("start_abort_idle", {busy, overrun, aborted}, 64'd0);
    tick();
    checkVal("start_abort_idle2", {busy, inject_en, done_pulse}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCnt, errCnt);
    $finish;
  end
endmodule
